// File: rtl/booth_pp_seq_accum_if.sv
// Operand, booth_pp and product bus for booth_pp_seq_accum.
// slave = the sequencer; master = the surrounding source/booth_pp/consumer.
interface booth_pp_seq_accum_if #(
  parameter int W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_x;
  logic [W-1:0]     in_y;
  logic [W-1:0]     pp_y;
  logic [2:0]       pp_booth_bits;
  logic [W:0]       pp_in;
  logic             cpl_in;
  logic             out_valid;
  logic             out_ready;
  logic [2*W-1:0]   out_product;

  modport slave (
    input  in_valid, in_x, in_y, pp_in, cpl_in, out_ready,
    output in_ready, pp_y, pp_booth_bits, out_valid, out_product
  );

  modport master (
    output in_valid, in_x, in_y, pp_in, cpl_in, out_ready,
    input  in_ready, pp_y, pp_booth_bits, out_valid, out_product
  );
endinterface

// File: rtl/booth_pp_seq_accum.sv
// Radix-4 Booth sequencer/accumulator around an external booth_pp (latency PP_LAT).
// Optional macro BOOTH_ACC_EARLY_EXIT_EN stops issuing once the remaining digits are all zero.
module booth_pp_seq_accum #(
  parameter int W      = 8,
  parameter int PP_LAT = 0
) (
  input  logic               clk,
  input  logic               rst,
  booth_pp_seq_accum_if.slave bus
);
  localparam int N  = W / 2;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int W2 = 2 * W;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t          r_state;
  logic [W-1:0]    r_x;
  logic [W-1:0]    r_y;
  logic [KW-1:0]   r_i;
  logic [2:0]      r_bits;
  logic [W2-1:0]   r_acc;
  logic [W2-1:0]   r_product;
  logic            r_in_ready;
  logic            r_out_valid;

  logic            w_ret_v;
  logic [KW-1:0]   w_ret_k;
  logic            w_pipe_more;
  logic            w_last;
  logic [W:0]      w_xe;
  logic [2:0]      w_next_bits;
  logic [W2-1:0]   w_pp_ext;
  logic [W2-1:0]   w_term;
  logic [W2-1:0]   w_acc_next;

  assign w_xe = {r_x, 1'b0};

`ifdef BOOTH_ACC_EARLY_EXIT_EN
  // w_fits[j]: x[W-1:2j-1] all equal, so digits j..N-1 are zero
  logic [W-2:0]  w_diff;
  logic [N:0]    w_fits;
  logic [KW:0]   w_nxt_idx;

  assign w_diff    = r_x[W-1:1] ^ r_x[W-2:0];
  assign w_nxt_idx = {1'b0, r_i} + (KW+1)'(1);

  always_comb begin
    w_fits    = '0;
    w_fits[N] = 1'b1;
    for (int j = 1; j < N; j++) begin
      w_fits[j] = ((w_diff >> (2 * j - 1)) == {(W-1){1'b0}});
    end
  end

  assign w_last = w_fits[w_nxt_idx];
`else
  assign w_last = (r_i == KW'(N - 1));
`endif

  always_comb begin
    w_next_bits = 3'b000;
    for (int k = 1; k < N; k++) begin
      if (!w_last && (r_i == KW'(k - 1))) begin
        w_next_bits = w_xe[2*k +: 3];
      end
    end
  end

  generate
    if (PP_LAT == 0) begin : g_ret_comb
      assign w_ret_v     = (r_state == S_ISSUE);
      assign w_ret_k     = r_i;
      assign w_pipe_more = 1'b0;
    end else begin : g_ret_pipe
      logic [PP_LAT-1:0] r_pv;
      logic [KW-1:0]     r_pk [PP_LAT];

      // {valid, digit} travels alongside the result inside booth_pp
      always_ff @(posedge clk) begin
        if (rst) begin
          r_pv <= '0;
          for (int s = 0; s < PP_LAT; s++) r_pk[s] <= '0;
        end else begin
          r_pv[0] <= (r_state == S_ISSUE);
          r_pk[0] <= r_i;
          for (int s = 1; s < PP_LAT; s++) begin
            r_pv[s] <= r_pv[s-1];
            r_pk[s] <= r_pk[s-1];
          end
        end
      end

      always_comb begin
        w_pipe_more = 1'b0;
        for (int s = 0; s < PP_LAT - 1; s++) w_pipe_more = w_pipe_more | r_pv[s];
      end

      assign w_ret_v = r_pv[PP_LAT-1];
      assign w_ret_k = r_pk[PP_LAT-1];
    end
  endgenerate

  assign w_pp_ext   = {{(W-1){bus.pp_in[W]}}, bus.pp_in};
  assign w_term     = (w_pp_ext + {{(W2-1){1'b0}}, bus.cpl_in}) << {w_ret_k, 1'b0};
  assign w_acc_next = w_ret_v ? (r_acc + w_term) : r_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_i         <= '0;
      r_bits      <= 3'b000;
      r_acc       <= '0;
      r_product   <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_x        <= bus.in_x;
            r_y        <= bus.in_y;
            r_i        <= '0;
            r_acc      <= '0;
            r_bits     <= {bus.in_x[1:0], 1'b0};
            r_in_ready <= 1'b0;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_acc  <= w_acc_next;
          r_bits <= w_next_bits;
          r_i    <= r_i + KW'(1);
          if (w_last) begin
            if (PP_LAT == 0) begin
              r_product   <= w_acc_next;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          r_acc <= w_acc_next;
          // the last in-order result is at the tail with nothing behind it
          if (w_ret_v && !w_pipe_more) begin
            r_product   <= w_acc_next;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready      = r_in_ready;
  assign bus.pp_y          = r_y;
  assign bus.pp_booth_bits = r_bits;
  assign bus.out_valid     = r_out_valid;
  assign bus.out_product   = r_product;
endmodule

// File: doc/booth_pp_seq_accum.md
Name: booth_pp_seq_accum

Overview:
Iterative radix-4 Booth multiplier sequencer and accumulator wrapped around a booth_pp instance.
- Upstream role: accepts signed operands, slices the multiplier into Booth triplets one digit per cycle, and drives booth_pp's y/booth_bits.
- Downstream role: consumes booth_pp's pp/cpl, shifts by digit position and accumulates into a 2W-bit signed product.
- Sits between the operand valid/ready source and the product consumer; booth_pp is instantiated by the parent and wired to the pp_* ports.

Parameters:
- W, 8, operand width in bits; must be even and >= 4; N = W/2 Booth digits.
- PP_LAT, 0, latency in cycles of the attached booth_pp (equals its PIPE); 0 = combinational.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- in_x  input  W  signed multiplier (Booth-recoded)
- in_y  input  W  signed multiplicand
- pp_y  output  W  multiplicand to booth_pp (latched in_y)
- pp_booth_bits  output  3  current Booth triplet to booth_pp
- pp_in  input  W+1  booth_pp partial product, signed
- cpl_in  input  1  booth_pp complement bit (+1 correction)
- out_valid  output  1  product valid
- out_ready  input  1  consumer accepts product
- out_product  output  2W  signed product in_x*in_y

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous, active-high.
- Reset values: in_ready=1 (state IDLE), out_valid=0, out_product=0, pp_y=0, pp_booth_bits=000, accumulator=0, digit counter=0, return pipe empty.
- Reset mid-operation: the operation in flight is discarded and no product is emitted. Any booth_pp results still returning are ignored.
- States:
  - IDLE: on in_valid&&in_ready, latch x, y; clear accumulator; i=0; go to ISSUE.
  - ISSUE: each cycle drive pp_booth_bits={x[2i+1],x[2i],x[2i-1]}, with x[-1]=0, then i++. After digit N-1 issues, go to DRAIN, or to DONE directly if PP_LAT=0.
  - DRAIN: wait until all PP_LAT in-flight results have been accumulated, then go to DONE.
  - DONE: out_valid=1 and out_product=accumulator, held stable until out_valid&&out_ready; then go to IDLE.
- pp_booth_bits=000 whenever not in ISSUE, so booth_pp outputs zero.
- Return alignment: the result for a digit issued in cycle t is sampled in cycle t+PP_LAT. A PP_LAT-deep shift register carries {valid, digit index} per issued digit; with PP_LAT=0 it is bypassed.
- Accumulate: acc <= acc + (sext_2W(pp_in) << 2k) + (cpl_in << 2k), where k is the returning digit index. Arithmetic is mod 2^2W; the exact product of two W-bit signed values always fits.
- Latency: handshake edge = cycle 0. ISSUE occupies cycles 1..N. out_valid rises in cycle N+PP_LAT+1 (W=8, PP_LAT=0: cycle 5).
- Throughput: one product per N+PP_LAT+2 cycles minimum; no overlap between operations.
- Backpressure: DONE holds indefinitely. in_ready=0 outside IDLE, so new operands are ignored until then.
- Simultaneous events: the out handshake and an in_valid in the same cycle do not start a new operation; acceptance happens in the following IDLE cycle.

Optional Feature:
- Macro: BOOTH_ACC_EARLY_EXIT_EN.
- Defined: in ISSUE, before issuing digit i>0, if x[W-1:2i-1] are all equal, every remaining digit is zero. The block stops issuing and proceeds to DRAIN/DONE.
  - out_valid then rises in cycle i+PP_LAT+1.
  - The product is identical to the full-length result.
- Undefined: all N digits are always issued; latency is fixed.

Test Plan:
- W=8, PP_LAT=0, x=7, y=5, out_ready=1 -> out_product=0x0023; out_valid high only in cycle 5; in_ready low in cycles 1..5.
- W=8, x=-128 (0x80), y=-128 -> out_product=0x4000; x=-128, y=127 -> 0xC080; x=0, y=0x55 -> 0x0000.
- W=8, x=0x13, y=0xF6, out_ready held 0 for 10 cycles after out_valid -> out_product=0xFF42 stable, in_ready=0 throughout; the block returns to IDLE the cycle after out_ready=1.
- W=8, PP_LAT=2 (booth_pp PIPE=2), x=-3, y=9 -> out_product=0xFFE5 in cycle 7.
- rst asserted in cycle 2 of an operation (x=7, y=5) -> the next cycle shows out_valid=0, in_ready=1, pp_booth_bits=000; a new x=2, y=3 then yields 0x0006.
- BOOTH_ACC_EARLY_EXIT_EN, W=8, PP_LAT=0, x=1, y=-7 -> out_product=0xFFF9 with out_valid in cycle 2. Without the macro, out_valid is in cycle 5.
